// File: rtl/xeng_ant_buf.sv
// Double-banked antenna sample buffer for the X-engine: one write stream, two read ports.
// Optional extra output register stage: define XENG_ANT_BUF_OUTREG_EN (read latency 3 instead of 2).
module xeng_ant_buf #(
  parameter int N_ANTS     = 16,
  parameter int DATA_WIDTH = 8,
  localparam int ANT_BITS  = $clog2(N_ANTS)
) (
  input  logic                  clk,
  input  logic                  sync,
  input  logic                  din_valid,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  input  logic [ANT_BITS-1:0]   ant_a,
  input  logic [ANT_BITS-1:0]   ant_b,
  input  logic                  buf_sel,
  output logic [DATA_WIDTH-1:0] dout_a,
  output logic [DATA_WIDTH-1:0] dout_b,
  output logic                  dout_valid,
  output logic                  wr_buf,
  output logic                  win_done,
  output logic                  rd_hazard
);

  logic [DATA_WIDTH-1:0] mem_q [2][N_ANTS];

  logic [ANT_BITS-1:0]   wr_idx_q, wr_idx_d;
  logic                  wr_buf_q, wr_buf_d;
  logic                  win_done_q, win_done_d;
  logic                  rd_hazard_q, rd_hazard_d;

  logic                  rd_v1_q, rd_v1_d;
  logic [DATA_WIDTH-1:0] rd_a1_q, rd_a1_d, rd_b1_q, rd_b1_d;
  logic                  rd_v2_q, rd_v2_d;
  logic [DATA_WIDTH-1:0] rd_a2_q, rd_a2_d, rd_b2_q, rd_b2_d;

  always_comb begin
    wr_idx_d    = wr_idx_q;
    wr_buf_d    = wr_buf_q;
    win_done_d  = 1'b0;
    rd_hazard_d = rd_hazard_q;
    if (din_valid) begin
      wr_idx_d = wr_idx_q + 1'b1;
      if (wr_idx_q == ANT_BITS'(N_ANTS - 1)) begin
        wr_buf_d   = ~wr_buf_q;
        win_done_d = 1'b1;
      end
    end
    if (rd_en && din_valid && (buf_sel == wr_buf_q) &&
        ((ant_a == wr_idx_q) || (ant_b == wr_idx_q)))
      rd_hazard_d = 1'b1;
  end

  // The bank is sampled in the rd_en cycle itself, alongside the address capture,
  // so a colliding write in that cycle cannot leak into the result (read-first).
  always_comb begin
    rd_v1_d = rd_en;
    rd_a1_d = rd_a1_q;
    rd_b1_d = rd_b1_q;
    if (rd_en) begin
      rd_a1_d = mem_q[buf_sel][ant_a];
      rd_b1_d = mem_q[buf_sel][ant_b];
    end
    rd_v2_d = rd_v1_q;
    rd_a2_d = rd_a2_q;
    rd_b2_d = rd_b2_q;
    if (rd_v1_q) begin
      rd_a2_d = rd_a1_q;
      rd_b2_d = rd_b1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!sync && din_valid)
      mem_q[wr_buf_q][wr_idx_q] <= din;
  end

  always_ff @(posedge clk) begin
    if (sync) begin
      wr_idx_q    <= '0;
      wr_buf_q    <= 1'b0;
      win_done_q  <= 1'b0;
      rd_hazard_q <= 1'b0;
      rd_v1_q     <= 1'b0;
      rd_v2_q     <= 1'b0;
      rd_a2_q     <= '0;
      rd_b2_q     <= '0;
    end else begin
      wr_idx_q    <= wr_idx_d;
      wr_buf_q    <= wr_buf_d;
      win_done_q  <= win_done_d;
      rd_hazard_q <= rd_hazard_d;
      rd_v1_q     <= rd_v1_d;
      rd_v2_q     <= rd_v2_d;
      rd_a2_q     <= rd_a2_d;
      rd_b2_q     <= rd_b2_d;
    end
    rd_a1_q <= rd_a1_d;
    rd_b1_q <= rd_b1_d;
  end

`ifdef XENG_ANT_BUF_OUTREG_EN
  logic                  rd_v3_q, rd_v3_d;
  logic [DATA_WIDTH-1:0] rd_a3_q, rd_a3_d, rd_b3_q, rd_b3_d;

  always_comb begin
    rd_v3_d = rd_v2_q;
    rd_a3_d = rd_a3_q;
    rd_b3_d = rd_b3_q;
    if (rd_v2_q) begin
      rd_a3_d = rd_a2_q;
      rd_b3_d = rd_b2_q;
    end
  end

  always_ff @(posedge clk) begin
    if (sync) begin
      rd_v3_q <= 1'b0;
      rd_a3_q <= '0;
      rd_b3_q <= '0;
    end else begin
      rd_v3_q <= rd_v3_d;
      rd_a3_q <= rd_a3_d;
      rd_b3_q <= rd_b3_d;
    end
  end

  assign dout_valid = rd_v3_q;
  assign dout_a     = rd_a3_q;
  assign dout_b     = rd_b3_q;
`else
  assign dout_valid = rd_v2_q;
  assign dout_a     = rd_a2_q;
  assign dout_b     = rd_b2_q;
`endif

  assign wr_buf    = wr_buf_q;
  assign win_done  = win_done_q;
  assign rd_hazard = rd_hazard_q;

endmodule

// File: tb/tb_xeng_ant_buf.sv
// Self-checking bench for xeng_ant_buf (N_ANTS=4): directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_xeng_ant_buf;

`ifdef XENG_ANT_BUF_OUTREG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic       clk = 1'b0;
  logic       sync = 1'b0, din_valid = 1'b0, rd_en = 1'b0, buf_sel = 1'b0;
  logic [7:0] din = '0;
  logic [1:0] ant_a = '0, ant_b = '0;
  logic [7:0] dout_a, dout_b;
  logic       dout_valid, wr_buf, win_done, rd_hazard;

  int errors = 0;
  int checks = 0;

  xeng_ant_buf #(.N_ANTS(4), .DATA_WIDTH(8)) dut (
    .clk(clk), .sync(sync), .din_valid(din_valid), .din(din), .rd_en(rd_en),
    .ant_a(ant_a), .ant_b(ant_b), .buf_sel(buf_sel), .dout_a(dout_a), .dout_b(dout_b),
    .dout_valid(dout_valid), .wr_buf(wr_buf), .win_done(win_done), .rd_hazard(rd_hazard)
  );

  always #5 clk = ~clk;

  // Reference model: plain arrays and a queue of reads with their due cycle.
  typedef struct { int due; logic [7:0] a; logic [7:0] b; } rd_t;
  logic [7:0] m_mem [2][4];
  int         m_idx = 0;
  logic       m_buf = 1'b0, m_hz = 1'b0, m_wd = 1'b0;
  rd_t        pend [$];
  int         cyc = 0;
  logic       e_valid = 1'b0;
  logic [7:0] e_a = '0, e_b = '0;

  task automatic step(input logic s, input logic dv, input logic [7:0] d, input logic re,
                      input logic [1:0] a, input logic [1:0] b, input logic sel);
    rd_t r;
    sync = s; din_valid = dv; din = d; rd_en = re; ant_a = a; ant_b = b; buf_sel = sel;
    @(posedge clk);
    if (s) begin
      m_idx = 0; m_buf = 1'b0; m_hz = 1'b0; m_wd = 1'b0;
      pend.delete();
      e_a = '0; e_b = '0;
    end else begin
      if (re) begin
        r.due = cyc + LAT; r.a = m_mem[sel][a]; r.b = m_mem[sel][b];
        pend.push_back(r);
        if (dv && sel == m_buf && (int'(a) == m_idx || int'(b) == m_idx)) m_hz = 1'b1;
      end
      m_wd = 1'b0;
      if (dv) begin
        m_mem[m_buf][m_idx] = d;
        m_idx = m_idx + 1;
        if (m_idx == 4) begin m_idx = 0; m_buf = ~m_buf; m_wd = 1'b1; end
      end
    end
    cyc = cyc + 1;
    e_valid = 1'b0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      r = pend.pop_front();
      e_valid = 1'b1; e_a = r.a; e_b = r.b;
    end
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 2'd0, 1'b0);
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 2'd0, 1'b0);
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", dout_valid); end
    checks++; if (dout_a !== 8'h00 || dout_b !== 8'h00) begin errors++; $display("FAIL reset_dout got=%h/%h exp=00/00", dout_a, dout_b); end
    checks++; if (wr_buf !== 1'b0 || win_done !== 1'b0 || rd_hazard !== 1'b0) begin
      errors++; $display("FAIL reset_flags got=%b%b%b exp=000", wr_buf, win_done, rd_hazard); end
  endtask

  task automatic test_window();
    int pulses = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 8'h10 + 8'(i), 1'b0, 2'd0, 2'd0, 1'b0);
      if (win_done === 1'b1) pulses++;
      if (i < 3) begin
        checks++; if (wr_buf !== 1'b0) begin errors++; $display("FAIL win_bufmid i=%0d got=%b exp=0", i, wr_buf); end
      end
    end
    idle();
    if (win_done === 1'b1) pulses++;
    checks++; if (pulses != 1) begin errors++; $display("FAIL win_pulses got=%0d exp=1", pulses); end
    checks++; if (wr_buf !== 1'b1) begin errors++; $display("FAIL win_wrbuf got=%b exp=1", wr_buf); end
    step(1'b0, 1'b0, 8'h00, 1'b1, 2'd1, 2'd3, 1'b0);
    for (int k = 1; k < LAT; k++) begin
      checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL win_early k=%0d got=%b exp=0", k, dout_valid); end
      idle();
    end
    checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL win_valid got=%b exp=1", dout_valid); end
    checks++; if (dout_a !== 8'h11 || dout_b !== 8'h13) begin errors++; $display("FAIL win_data got=%h/%h exp=11/13", dout_a, dout_b); end
    idle();
    checks++; if (dout_valid !== 1'b0 || dout_a !== 8'h11) begin
      errors++; $display("FAIL win_hold got=%b/%h exp=0/11", dout_valid, dout_a); end
  endtask

  task automatic test_gap();
    int pulses = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 8'h20 + 8'(i), 1'b0, 2'd0, 2'd0, 1'b0);
      if (win_done === 1'b1) pulses++;
      idle();
      if (win_done === 1'b1) pulses++;
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL gap_pulses got=%0d exp=1", pulses); end
    checks++; if (wr_buf !== 1'b0) begin errors++; $display("FAIL gap_wrbuf got=%b exp=0", wr_buf); end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b1, 2'(i), 2'(3 - i), 1'b1);
      for (int k = 1; k < LAT; k++) idle();
      checks++; if (dout_valid !== 1'b1 || dout_a !== 8'h20 + 8'(i) || dout_b !== 8'h23 - 8'(i)) begin
        errors++; $display("FAIL gap_read i=%0d got=%b/%h/%h exp=1/%h/%h", i, dout_valid, dout_a, dout_b,
                            8'h20 + 8'(i), 8'h23 - 8'(i)); end
    end
  endtask

  task automatic test_hazard();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'h30 + 8'(i), 1'b0, 2'd0, 2'd0, 1'b0);
    step(1'b0, 1'b1, 8'h40, 1'b0, 2'd0, 2'd0, 1'b0);
    step(1'b0, 1'b1, 8'h41, 1'b0, 2'd0, 2'd0, 1'b0);
    checks++; if (rd_hazard !== 1'b0) begin errors++; $display("FAIL hz_before got=%b exp=0", rd_hazard); end
    step(1'b0, 1'b1, 8'hAA, 1'b1, 2'd2, 2'd0, 1'b1);
    checks++; if (rd_hazard !== 1'b1) begin errors++; $display("FAIL hz_set got=%b exp=1", rd_hazard); end
    for (int k = 1; k < LAT; k++) idle();
    checks++; if (dout_a !== 8'h22 || dout_b !== 8'h40) begin errors++; $display("FAIL hz_readfirst got=%h/%h exp=22/40", dout_a, dout_b); end
    step(1'b0, 1'b0, 8'h00, 1'b1, 2'd2, 2'd2, 1'b1);
    for (int k = 1; k < LAT; k++) idle();
    checks++; if (dout_a !== 8'hAA || dout_b !== 8'hAA) begin errors++; $display("FAIL hz_newdata got=%h/%h exp=aa/aa", dout_a, dout_b); end
    for (int k = 0; k < 3; k++) idle();
    checks++; if (rd_hazard !== 1'b1) begin errors++; $display("FAIL hz_sticky got=%b exp=1", rd_hazard); end
  endtask

  task automatic test_sync_mid();
    int pulses = 0;
    step(1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 2'd0, 1'b0);
    step(1'b0, 1'b1, 8'h60, 1'b0, 2'd0, 2'd0, 1'b0);
    step(1'b0, 1'b1, 8'h61, 1'b0, 2'd0, 2'd0, 1'b0);
    // Sync alongside a write and a read: neither may take effect.
    step(1'b1, 1'b1, 8'hEE, 1'b1, 2'd0, 2'd1, 1'b0);
    checks++; if (wr_buf !== 1'b0 || rd_hazard !== 1'b0 || win_done !== 1'b0) begin
      errors++; $display("FAIL sync_flags got=%b%b%b exp=000", wr_buf, rd_hazard, win_done); end
    for (int k = 0; k < LAT + 1; k++) begin
      checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL sync_noread k=%0d got=%b exp=0", k, dout_valid); end
      if (k < LAT) idle();
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 8'h50 + 8'(i), 1'b0, 2'd0, 2'd0, 1'b0);
      if (win_done === 1'b1) pulses++;
    end
    idle();
    if (win_done === 1'b1) pulses++;
    checks++; if (pulses != 1) begin errors++; $display("FAIL sync_pulses got=%0d exp=1", pulses); end
    step(1'b0, 1'b0, 8'h00, 1'b1, 2'd0, 2'd2, 1'b0);
    for (int k = 1; k < LAT; k++) idle();
    checks++; if (dout_a !== 8'h50 || dout_b !== 8'h52) begin errors++; $display("FAIL sync_restart got=%h/%h exp=50/52", dout_a, dout_b); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8 + LAT; i++) begin
      if (i < 8) step(1'b0, 1'b0, 8'h00, 1'b1, 2'(i % 4), 2'(3 - i % 4), 1'b0);
      else idle();
      if (i + 1 >= LAT && i + 1 < LAT + 8) begin
        checks++;
        if (dout_valid !== 1'b1 || dout_a !== 8'h50 + 8'((i + 1 - LAT) % 4) || dout_b !== 8'h53 - 8'((i + 1 - LAT) % 4)) begin
          errors++; $display("FAIL b2b i=%0d got=%b/%h/%h exp=1/%h/%h", i, dout_valid, dout_a, dout_b,
                              8'h50 + 8'((i + 1 - LAT) % 4), 8'h53 - 8'((i + 1 - LAT) % 4)); end
      end else begin
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle i=%0d got=%b exp=0", i, dout_valid); end
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 39) == 0), 1'($urandom), 8'($urandom), 1'($urandom),
           2'($urandom), 2'($urandom), 1'($urandom));
      checks++;
      if (dout_valid !== e_valid || dout_a !== e_a || dout_b !== e_b) begin
        errors++; $display("FAIL rand_dout n=%0d got=%b/%h/%h exp=%b/%h/%h", n, dout_valid, dout_a, dout_b, e_valid, e_a, e_b); end
      checks++;
      if (wr_buf !== m_buf || win_done !== m_wd || rd_hazard !== m_hz) begin
        errors++; $display("FAIL rand_flags n=%0d got=%b%b%b exp=%b%b%b", n, wr_buf, win_done, rd_hazard, m_buf, m_wd, m_hz); end
    end
  endtask

  initial begin
    test_reset();
    test_window();
    test_gap();
    test_hazard();
    test_sync_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
